// File: rtl/dmem_responder.sv
// CPU data-memory responder: DEPTH-word array behind a posted-write FIFO with read forwarding, plus a loader port.
// Optional feature macro DMEM_SCRUB_EN: when defined, a post-reset INIT sequence zeroes the array before RUN.
module dmem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 6,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_w_en,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [WIDTH-1:0]  dmem_wdata,
    output logic [WIDTH-1:0]  dmem_rdata,
    output logic              dmem_stall,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_wdata,
    output logic              ld_ready,
    output logic              init_done,
    output logic              err_overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(WBUF_DEPTH);
    localparam logic [PTR_W:0] STALL_CNT = (PTR_W + 1)'(WBUF_DEPTH - 1);

    logic [WIDTH-1:0]  mem       [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
    logic [WIDTH-1:0]  fifo_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              in_run;
    logic              full;
    logic              drain;
    logic              enq;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              hit;
    logic [WIDTH-1:0]  hit_data;
    logic [PTR_W-1:0]  hit_idx;

`ifdef DMEM_SCRUB_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clear_cnt;
    logic [ADDR_W-1:0] clear_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            clear_cnt <= '0;
        end else begin
            state     <= state_nxt;
            clear_cnt <= clear_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_cnt_nxt = clear_cnt;
        if (state == ST_INIT) begin
            clear_cnt_nxt = clear_cnt + 1'b1;
            if (clear_cnt == '1) begin
                state_nxt = ST_RUN;
            end
        end
    end

    assign in_run = (state == ST_RUN);
`else
    // Without the clear sequence the responder is in RUN from the first edge after reset.
    logic run_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign in_run = run_q;
`endif

    assign init_done  = in_run;
    assign full       = (count == FULL_CNT);
    assign drain      = in_run && (count != '0);
    // A full FIFO still accepts a store when the same edge pops an entry.
    assign enq        = dmem_w_en && (!full || drain);
    assign dmem_stall = (count >= STALL_CNT);
    assign ld_ready   = in_run && (count == '0) && !dmem_w_en && ld_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dmem_w_en && !enq) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= dmem_addr;
            fifo_data[wr_ptr] <= dmem_wdata;
        end
    end

    // Single array write port: clear, then FIFO drain, then loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_we    = 1'b1;
            mem_waddr = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
        end else if (ld_ready) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_wdata;
        end
`ifdef DMEM_SCRUB_EN
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clear_cnt;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest entry.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        hit_idx  = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            hit_idx = rd_ptr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (fifo_addr[hit_idx] == dmem_addr)) begin
                hit      = 1'b1;
                hit_data = fifo_data[hit_idx];
            end
        end
    end

    always_comb begin
        dmem_rdata = mem[dmem_addr];
`ifdef DMEM_SCRUB_EN
        if ((state == ST_INIT) && (dmem_addr >= clear_cnt)) begin
            dmem_rdata = '0;
        end
`endif
        if (hit) begin
            dmem_rdata = hit_data;
        end
    end

endmodule
